// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the CPU read-path AXI arbiter and the read adapter:
// AXI constant fields, requester IDs, FSM encodings and the kseg address map.
package axi_read_arbiter_pkg;

   localparam int ADDR_W = 32;

   localparam logic [3:0] ID_INST = 4'd0;
   localparam logic [3:0] ID_DATA = 4'd1;

   localparam logic [3:0] AR_LEN   = 4'd0;
   localparam logic [2:0] AR_SIZE  = 3'b010;
   localparam logic [1:0] AR_BURST = 2'b00;
   localparam logic [1:0] AR_LOCK  = 2'b00;
   localparam logic [3:0] AR_CACHE = 4'b0000;
   localparam logic [2:0] AR_PROT  = 3'b001;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) fold onto physical 0..0x1FFF_FFFF.
   function automatic logic [ADDR_W-1:0] kseg_map(input logic [ADDR_W-1:0] addr);
      if (addr[31:29] == 3'b100 || addr[31:29] == 3'b101)
         return {3'b000, addr[28:0]};
      return addr;
   endfunction

endpackage

// File: rtl/axi_id_tracker.sv
// Per-ID bookkeeping: outstanding AR count, count of responses still to be
// discarded after a flush, and a small FIFO of the unmapped request addresses.
module axi_id_tracker
   import axi_read_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_W           = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ar_done,
   input  logic [ADDR_W-1:0] ar_addr,
   input  logic              ar_pending,
   input  logic              r_beat,
   input  logic              flush,
   output logic              at_limit,
   output logic              suppress,
   output logic [ADDR_W-1:0] front_addr
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   logic [CNT_W-1:0]  out_cnt;
   logic [CNT_W-1:0]  drop_cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [ADDR_W-1:0] fifo_mem [MAX_OUTSTANDING];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // A handshake and a beat in the same cycle cancel out.
   assign cnt_next   = out_cnt + CNT_W'(ar_done) - CNT_W'(r_beat);
   assign at_limit   = (out_cnt >= CNT_W'(MAX_OUTSTANDING));
   assign suppress   = flush || (drop_cnt != '0);
   assign front_addr = fifo_mem[rd_ptr];

   // Outstanding and drop counters; a flush re-arms drop_cnt to cover every
   // response still owed, including an AR that is issued but not yet accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         out_cnt <= cnt_next;
         if (flush)
            drop_cnt <= cnt_next + CNT_W'(ar_pending);
         else if (r_beat && drop_cnt != '0)
            drop_cnt <= drop_cnt - CNT_W'(1);
      end
   end

   // FIFO pointers: push on AR handshake, pop on every beat of this ID.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (ar_done) wr_ptr <= ptr_inc(wr_ptr);
         if (r_beat)  rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   // FIFO storage holds data only, so it needs no reset.
   always_ff @(posedge clk) begin
      if (ar_done) fifo_mem[wr_ptr] <= ar_addr;
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI3 AR/R channel pair between instruction
// fetch (ID 0) and data load (ID 1), with flush-aware inst response dropping.
module axi_read_arbiter
   import axi_read_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_W           = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] inst_addr,
   input  logic        inst_addr_valid,
   output logic        inst_addr_ready,
   input  logic        inst_flush,
   output logic        inst_data_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_data_address,
   input  logic [31:0] data_addr,
   input  logic        data_addr_valid,
   output logic        data_addr_ready,
   output logic        data_data_valid,
   output logic [31:0] data_data
);

   logic [0:0]  state;
   logic        last_grant;   // 0: inst granted last, 1: data granted last
   logic [31:0] ar_uaddr;
   logic        i_elig, d_elig, grant_i, grant_d;
   logic        ar_hs, i_ar_done, d_ar_done, i_ar_pending;
   logic        r_inst, r_data, i_deliver;
   logic        i_at_limit, i_suppress, d_at_limit, d_suppress;
   logic [31:0] i_front, d_front;
   logic        unused_bits;

   assign arlen   = AR_LEN;
   assign arsize  = AR_SIZE;
   assign arburst = AR_BURST;
   assign arlock  = AR_LOCK;
   assign arcache = AR_CACHE;
   assign arprot  = AR_PROT;
   assign rready  = 1'b1;

   // Single-beat bursts make rlast/rresp irrelevant; the data tracker never drops.
   assign unused_bits = ^{rresp, rlast, d_suppress, d_front};

   assign i_elig  = inst_addr_valid && !i_at_limit;
   assign d_elig  = data_addr_valid && !d_at_limit;
   assign grant_i = !reset && (state == ST_IDLE) && i_elig && (!d_elig || last_grant);
   assign grant_d = !reset && (state == ST_IDLE) && d_elig && (!i_elig || !last_grant);
   assign inst_addr_ready = grant_i;
   assign data_addr_ready = grant_d;

   assign ar_hs        = (state == ST_ISSUE) && arvalid && arready;
   assign i_ar_done    = ar_hs && (arid == ID_INST);
   assign d_ar_done    = ar_hs && (arid == ID_DATA);
   assign i_ar_pending = (state == ST_ISSUE) && (arid == ID_INST) && !arready;

   assign r_inst    = !reset && rvalid && (rid == ID_INST);
   assign r_data    = !reset && rvalid && (rid == ID_DATA);
   assign i_deliver = r_inst && !i_suppress;

   assign inst_data_valid   = i_deliver;
   assign inst_data         = i_deliver ? rdata : '0;
   assign inst_data_address = i_deliver ? i_front : '0;
   assign data_data_valid   = r_data;
   assign data_data         = r_data ? rdata : '0;

   // AR issue FSM: latch the granted request, hold it until arready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         arvalid    <= 1'b0;
         araddr     <= '0;
         arid       <= '0;
         last_grant <= 1'b0;
         ar_uaddr   <= '0;
      end else if (state == ST_IDLE) begin
         if (grant_i || grant_d) begin
            state      <= ST_ISSUE;
            arvalid    <= 1'b1;
            arid       <= grant_d ? ID_DATA : ID_INST;
            araddr     <= kseg_map(grant_d ? data_addr : inst_addr);
            ar_uaddr   <= grant_d ? data_addr : inst_addr;
            last_grant <= grant_d;
         end
      end else if (arready) begin
         state   <= ST_IDLE;
         arvalid <= 1'b0;
      end
   end

   axi_id_tracker #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING),
      .CNT_W          (CNT_W)
   ) u_inst_tracker (
      .clk       (clk),
      .reset     (reset),
      .ar_done   (i_ar_done),
      .ar_addr   (ar_uaddr),
      .ar_pending(i_ar_pending),
      .r_beat    (r_inst),
      .flush     (inst_flush),
      .at_limit  (i_at_limit),
      .suppress  (i_suppress),
      .front_addr(i_front)
   );

   axi_id_tracker #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING),
      .CNT_W          (CNT_W)
   ) u_data_tracker (
      .clk       (clk),
      .reset     (reset),
      .ar_done   (d_ar_done),
      .ar_addr   (ar_uaddr),
      .ar_pending(1'b0),
      .r_beat    (r_data),
      .flush     (1'b0),
      .at_limit  (d_at_limit),
      .suppress  (d_suppress),
      .front_addr(d_front)
   );

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: scoreboard queues of expected AR
// issues and routed responses, filled as stimulus is driven.
module tb_axi_read_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst_addr;
   logic        inst_addr_valid;
   logic        inst_addr_ready;
   logic        inst_flush;
   logic        inst_data_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_data_address;
   logic [31:0] data_addr;
   logic        data_addr_valid;
   logic        data_addr_ready;
   logic        data_data_valid;
   logic [31:0] data_data;

   always #5 clk = ~clk;

   axi_read_arbiter dut (
      .clk(clk), .reset(reset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready),
      .inst_addr(inst_addr), .inst_addr_valid(inst_addr_valid),
      .inst_addr_ready(inst_addr_ready), .inst_flush(inst_flush),
      .inst_data_valid(inst_data_valid), .inst_data(inst_data),
      .inst_data_address(inst_data_address),
      .data_addr(data_addr), .data_addr_valid(data_addr_valid),
      .data_addr_ready(data_addr_ready), .data_data_valid(data_data_valid),
      .data_data(data_data)
   );

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
   } ar_t;

   ar_t         q_ar[$];
   logic [63:0] q_inst[$];   // {address, data}
   logic [31:0] q_data[$];

   int n_cmp = 0;
   int n_err = 0;

   logic        iready_s, dready_s, ivld_s, dvld_s;
   logic [31:0] idata_s, ddata_s;

   // Independent address model: 0x8000_0000..0xBFFF_FFFF lose the top 3 bits.
   function automatic logic [31:0] map_addr(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
      return a;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      ar_t         ea;
      logic [63:0] ei;
      logic [31:0] ed;
      if (arvalid && arready) begin
         if (q_ar.size() == 0) chk("ar_unexpected", 64'(arvalid), 64'd0);
         else begin
            ea = q_ar.pop_front();
            chk("arid", 64'(arid), 64'(ea.id));
            chk("araddr", 64'(araddr), 64'(ea.addr));
            chk("ar_consts", 64'({arlen, arsize, arburst, arlock, arcache, arprot, rready}),
                64'({4'd0, 3'b010, 2'd0, 2'd0, 4'd0, 3'b001, 1'b1}));
         end
      end
      if (inst_data_valid) begin
         if (q_inst.size() == 0) chk("inst_unexpected", 64'(inst_data_valid), 64'd0);
         else begin
            ei = q_inst.pop_front();
            chk("inst_data", 64'(inst_data), 64'(ei[31:0]));
            chk("inst_data_address", 64'(inst_data_address), 64'(ei[63:32]));
         end
      end
      if (data_data_valid) begin
         if (q_data.size() == 0) chk("data_unexpected", 64'(data_data_valid), 64'd0);
         else begin
            ed = q_data.pop_front();
            chk("data_data", 64'(data_data), 64'(ed));
         end
      end
   endtask

   // One clock: sample on the falling edge, advance, release accepted requests.
   task automatic tick();
      @(negedge clk);
      monitor();
      iready_s = inst_addr_ready;
      dready_s = data_addr_ready;
      ivld_s   = inst_data_valid;
      dvld_s   = data_data_valid;
      idata_s  = inst_data;
      ddata_s  = data_data;
      @(posedge clk);
      #1;
      if (iready_s) inst_addr_valid = 1'b0;
      if (dready_s) data_addr_valid = 1'b0;
      rvalid     = 1'b0;
      inst_flush = 1'b0;
   endtask

   task automatic req_i(input logic [31:0] a);
      inst_addr       = a;
      inst_addr_valid = 1'b1;
      q_ar.push_back({4'd0, map_addr(a)});
   endtask

   task automatic req_d(input logic [31:0] a);
      data_addr       = a;
      data_addr_valid = 1'b1;
      q_ar.push_back({4'd1, map_addr(a)});
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 20 && (inst_addr_valid || data_addr_valid || arvalid); k++) tick();
      chk("wait_idle_timeout", 64'(inst_addr_valid | data_addr_valid | arvalid), 64'd0);
   endtask

   task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic deliver,
                       input logic [31:0] a);
      logic exp_i;
      logic exp_d;
      exp_i  = (id == 4'd0) && deliver;
      exp_d  = (id == 4'd1);
      rid    = id;
      rdata  = d;
      rvalid = 1'b1;
      if (exp_d) q_data.push_back(d);
      if (exp_i) q_inst.push_back({a, d});
      tick();
      chk("beat_inst_valid", 64'(ivld_s), 64'(exp_i));
      chk("beat_data_valid", 64'(dvld_s), 64'(exp_d));
      if (!exp_i) chk("inst_data_zero", 64'(idata_s), 64'd0);
      if (!exp_d) chk("data_data_zero", 64'(ddata_s), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      arready = 1'b0;
      rid = 4'd0; rdata = '0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
      inst_addr = '0; inst_addr_valid = 1'b0; inst_flush = 1'b0;
      data_addr = '0; data_addr_valid = 1'b0;
      #1;
      chk("rst_arvalid", 64'(arvalid), 64'd0);
      chk("rst_araddr", 64'(araddr), 64'd0);
      chk("rst_arid", 64'(arid), 64'd0);
      chk("rst_readies", 64'({inst_addr_ready, data_addr_ready}), 64'd0);
      chk("rst_outputs", 64'({inst_data_valid, data_data_valid} | inst_data | data_data
                             | inst_data_address), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Single fetch with arready held low for three cycles
      req_i(32'hBFC0_0000);
      tick();
      chk("t1_iready", 64'(iready_s), 64'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t1_arvalid_held", 64'(arvalid), 64'd1);
         chk("t1_araddr_held", 64'(araddr), 64'h1FC0_0000);
         chk("t1_arid_held", 64'(arid), 64'd0);
      end
      arready = 1'b1;
      tick();
      chk("t1_arvalid_drop", 64'(arvalid), 64'd0);
      beat(4'd0, 32'hCAFE_0001, 1'b1, 32'hBFC0_0000);

      // Conflict with last grant = inst: data wins, then inst
      inst_addr = 32'h8000_1000; inst_addr_valid = 1'b1;
      data_addr = 32'h0000_2000; data_addr_valid = 1'b1;
      q_ar.push_back({4'd1, 32'h0000_2000});
      q_ar.push_back({4'd0, 32'h0000_1000});
      tick();
      chk("c1_dready", 64'(dready_s), 64'd1);
      chk("c1_iready", 64'(iready_s), 64'd0);
      tick();
      tick();
      chk("c1_iready_next", 64'(iready_s), 64'd1);
      wait_idle();
      beat(4'd1, 32'hD000_0001, 1'b0, 32'h0);
      beat(4'd0, 32'h1000_0002, 1'b1, 32'h8000_1000);
      req_d(32'hA000_3000);
      wait_idle();
      // Second conflict after a data grant: inst wins
      inst_addr = 32'h9FC0_0010; inst_addr_valid = 1'b1;
      data_addr = 32'hC000_0000; data_addr_valid = 1'b1;
      q_ar.push_back({4'd0, 32'h1FC0_0010});
      q_ar.push_back({4'd1, 32'hC000_0000});
      tick();
      chk("c2_iready", 64'(iready_s), 64'd1);
      chk("c2_dready", 64'(dready_s), 64'd0);
      wait_idle();
      beat(4'd1, 32'hD000_0003, 1'b0, 32'h0);
      beat(4'd1, 32'hD000_0004, 1'b0, 32'h0);
      beat(4'd0, 32'h1000_0005, 1'b1, 32'h9FC0_0010);

      // Flush with two inst reads outstanding; data traffic unaffected
      req_i(32'hBFC0_0100); wait_idle();
      req_i(32'hBFC0_0104); wait_idle();
      req_d(32'h0000_4000); wait_idle();
      inst_flush = 1'b1;
      tick();
      beat(4'd0, 32'hBAD0_0001, 1'b0, 32'h0);
      beat(4'd1, 32'hD000_0006, 1'b0, 32'h0);
      beat(4'd0, 32'hBAD0_0002, 1'b0, 32'h0);
      req_i(32'hBFC0_0108); wait_idle();
      beat(4'd0, 32'h1000_0007, 1'b1, 32'hBFC0_0108);

      // Flush while an inst AR waits in ISSUE, plus a beat in the flush cycle
      req_i(32'h0040_0000); wait_idle();
      arready = 1'b0;
      req_i(32'h0040_0004);
      tick();
      inst_flush = 1'b1;
      beat(4'd0, 32'hBAD0_0003, 1'b0, 32'h0);
      arready = 1'b1;
      tick();
      beat(4'd0, 32'hBAD0_0004, 1'b0, 32'h0);
      req_i(32'h0040_0008); wait_idle();
      beat(4'd0, 32'h1000_0008, 1'b1, 32'h0040_0008);

      // Outstanding limit: third inst request waits for a returned beat
      req_i(32'h8000_0100); wait_idle();
      req_i(32'h8000_0104); wait_idle();
      req_i(32'h8000_0108);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t4_no_ready_at_limit", 64'(iready_s), 64'd0);
      end
      beat(4'd0, 32'h1000_0009, 1'b1, 32'h8000_0100);
      chk("t4_no_ready_beat_cycle", 64'(iready_s), 64'd0);
      tick();
      chk("t4_ready_after_beat", 64'(iready_s), 64'd1);
      wait_idle();
      beat(4'd0, 32'h1000_000A, 1'b1, 32'h8000_0104);
      beat(4'd0, 32'h1000_000B, 1'b1, 32'h8000_0108);

      // Asynchronous reset during ISSUE with counters and drop count loaded
      req_i(32'h0000_0100); wait_idle();
      req_i(32'h0000_0104); wait_idle();
      inst_flush = 1'b1;
      tick();
      arready = 1'b0;
      req_d(32'h0000_5000);
      tick();
      chk("t5_arvalid_before_reset", 64'(arvalid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_arvalid_async", 64'(arvalid), 64'd0);
      chk("t5_ar_regs_async", 64'({arid, araddr}), 64'd0);
      chk("t5_readies_in_reset", 64'({inst_addr_ready, data_addr_ready}), 64'd0);
      data_addr_valid = 1'b0;
      q_ar.delete();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      arready = 1'b1;
      req_i(32'h0000_0200); wait_idle();
      req_i(32'h0000_0204); wait_idle();
      beat(4'd0, 32'h1000_000C, 1'b1, 32'h0000_0200);
      beat(4'd0, 32'h1000_000D, 1'b1, 32'h0000_0204);

      // Foreign rid ignored; interleaved out-of-order IDs routed correctly
      req_i(32'hA000_0300); wait_idle();
      req_d(32'h8000_6000); wait_idle();
      req_i(32'hA000_0304); wait_idle();
      beat(4'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
      beat(4'd1, 32'hD000_000E, 1'b0, 32'h0);
      beat(4'd0, 32'h1000_000F, 1'b1, 32'hA000_0300);
      beat(4'd5, 32'hDEAD_0005, 1'b0, 32'h0);
      beat(4'd0, 32'h1000_0010, 1'b1, 32'hA000_0304);

      chk("sb_ar_drained", 64'(q_ar.size()), 64'd0);
      chk("sb_inst_drained", 64'(q_inst.size()), 64'd0);
      chk("sb_data_drained", 64'(q_data.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
